// File: rtl/ahb_dma_cfg_regs.sv
// AHB-Lite register bank configuring NUM_CH edge-detection channels: image size,
// source/destination bases and a start/busy/done control FSM per channel.
module ahb_dma_cfg_regs #(
    parameter int NUM_CH = 2,
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [ADDR_W-1:0]        HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic [31:0]              HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [NUM_CH*DIM_W-1:0]  length,
    output logic [NUM_CH*DIM_W-1:0]  width,
    output logic [NUM_CH*32-1:0]     source_addr,
    output logic [NUM_CH*32-1:0]     dest_addr,
    output logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        done
);
    localparam int CH_W = ADDR_W - 4;

    typedef enum logic {ST_IDLE, ST_BUSY} ch_state_t;

    logic              dp_active, dp_write, dp_size_ok, err2;
    logic [CH_W-1:0]   dp_ch;
    logic [1:0]        dp_reg;
    logic              ch_ok, sel_busy, dp_err, err1, wr_en;
    logic [NUM_CH-1:0] ch_hit, ctl_hit;
    logic              unused_bits;

    ch_state_t         state_q [NUM_CH];
    logic [DIM_W-1:0]  len_q   [NUM_CH];
    logic [DIM_W-1:0]  wid_q   [NUM_CH];
    logic [31:0]       src_q   [NUM_CH];
    logic [31:0]       dst_q   [NUM_CH];
    logic [NUM_CH-1:0] start_q, done_st, err_st;

    assign unused_bits = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA};

    // Address phase capture; held while the bus is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_active  <= 1'b0;
            dp_write   <= 1'b0;
            dp_size_ok <= 1'b0;
            dp_ch      <= '0;
            dp_reg     <= '0;
            err2       <= 1'b0;
        end else begin
            err2 <= err1;
            if (HREADY) begin
                dp_active  <= HSEL & HTRANS[1];
                dp_write   <= HWRITE;
                dp_size_ok <= (HSIZE == 3'b010);
                dp_ch      <= HADDR[ADDR_W-1:4];
                dp_reg     <= HADDR[3:2];
            end
        end
    end

    // Errors need the write data (start bit), so they are decided in the data phase.
    always_comb begin
        sel_busy = 1'b0;
        ch_hit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(dp_ch) == i) sel_busy = (state_q[i] == ST_BUSY);
        end
        ch_ok  = (32'(dp_ch) < NUM_CH);
        dp_err = dp_active & (~ch_ok | ~dp_size_ok |
                 (dp_write & sel_busy & ((dp_reg != 2'd3) | HWDATA[0])));
        err1   = dp_err & ~err2;
        wr_en  = dp_active & dp_write & HREADY & ~dp_err & ~err2;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = wr_en & (32'(dp_ch) == i);
        end
        ctl_hit = ch_hit & {NUM_CH{dp_reg == 2'd3}};
    end

    assign HREADYOUT = ~err1;
    assign HRESP     = err1 | err2;

    always_comb begin
        HRDATA = '0;
        if (dp_active && !dp_write && !dp_err && !err2) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (32'(dp_ch) == i) begin
                    case (dp_reg)
                        2'd0:    HRDATA = {16'(len_q[i]), 16'(wid_q[i])};
                        2'd1:    HRDATA = src_q[i];
                        2'd2:    HRDATA = dst_q[i];
                        default: HRDATA = {29'd0, err_st[i], done_st[i], state_q[i] == ST_BUSY};
                    endcase
                end
            end
        end
    end

    // Per-channel registers and FSM; sticky sets are ordered after clears so a set wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                len_q[i]   <= '0;
                wid_q[i]   <= '0;
                src_q[i]   <= '0;
                dst_q[i]   <= '0;
            end
            start_q <= '0;
            done_st <= '0;
            err_st  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                start_q[i] <= 1'b0;
                if (ch_hit[i]) begin
                    case (dp_reg)
                        2'd0: begin
                            len_q[i] <= HWDATA[16 +: DIM_W];
                            wid_q[i] <= HWDATA[0 +: DIM_W];
                        end
                        2'd1:    src_q[i] <= HWDATA;
                        2'd2:    dst_q[i] <= HWDATA;
                        default: ;
                    endcase
                end
                if (ctl_hit[i] && HWDATA[1]) done_st[i] <= 1'b0;
                if (ctl_hit[i] && HWDATA[2]) err_st[i]  <= 1'b0;
                case (state_q[i])
                    ST_IDLE: begin
                        if (ctl_hit[i] && HWDATA[0]) begin
                            if (len_q[i] != '0 && wid_q[i] != '0) begin
                                state_q[i] <= ST_BUSY;
                                start_q[i] <= 1'b1;
                            end else begin
                                err_st[i] <= 1'b1;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (done[i]) begin
                            state_q[i] <= ST_IDLE;
                            done_st[i] <= 1'b1;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign length[g*DIM_W +: DIM_W] = len_q[g];
        assign width[g*DIM_W +: DIM_W]  = wid_q[g];
        assign source_addr[g*32 +: 32]  = src_q[g];
        assign dest_addr[g*32 +: 32]    = dst_q[g];
    end
    assign start = start_q;

endmodule

// File: doc/ahb_dma_cfg_regs.md
# ahb_dma_cfg_regs

AHB-Lite slave register bank that configures NUM_CH independent image-processing channels of the edge-detection engine. Per channel it holds image dimensions, source and destination addresses, a start/busy/done control FSM and sticky status. It sits between the AHB bus and the per-channel read/write DMA masters, and replaces the single-channel size/source/dest decoder.

## Interface
- NUM_CH, 2: number of channels, 1..16.
- DIM_W, 16: width of length/width fields, 1..16.
- ADDR_W, 8: decoded HADDR bits; must be >= 4 + clog2(NUM_CH).
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  transfer type; NONSEQ/SEQ = HTRANS[1]=1.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- length  out  NUM_CH*DIM_W  per-channel image length; ch i at [i*DIM_W +: DIM_W].
- width  out  NUM_CH*DIM_W  per-channel image width; same packing.
- source_addr  out  NUM_CH*32  per-channel source base.
- dest_addr  out  NUM_CH*32  per-channel destination base.
- start  out  NUM_CH  one-cycle start pulse per channel.
- done  in  NUM_CH  one-cycle completion pulse from the engine.

## Operation
- Address decode:
  - ch = HADDR[ADDR_W-1:4]; reg = HADDR[3:2]; HADDR[1:0] ignored.
  - reg 0 SIZE: length in [31:16], width in [15:0]. Only the low DIM_W bits of each field are stored; reads zero-extend.
  - reg 1 SRC, reg 2 DST: 32-bit addresses.
  - reg 3 CTRL/STAT:
    - Write bit0=1: start request. Write bit1=1: clear done_sticky. Write bit2=1: clear err_sticky.
    - Read: bit0 busy, bit1 done_sticky, bit2 err_sticky, other bits 0.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. Captured: ch, reg, HWRITE, size_ok.
- ERROR response (two-cycle), no register change, for any of:
  - ch >= NUM_CH;
  - HSIZE != word;
  - write to SIZE/SRC/DST while that channel is busy;
  - start request while that channel is busy.
- All other transfers are zero-wait OKAY.
- Per-channel FSM:
  - IDLE: CTRL write with bit0=1:
    - If length != 0 and width != 0: go to BUSY and pulse start.
    - Otherwise stay in IDLE and set err_sticky; the bus response is still OKAY.
  - BUSY: done=1 returns to IDLE and sets done_sticky. done while IDLE is ignored.
- Simultaneous events:
  - CTRL write with bit1=1 and done in the same cycle: done_sticky ends at 1 (set wins).
  - Start-while-IDLE plus a clear bit in the same write: both take effect.
- Outputs length/width/source_addr/dest_addr are direct register values, stable while BUSY.

## Timing
- Reset values:
  - All length, width, source_addr and dest_addr = 0.
  - All FSMs IDLE; sticky bits 0; start = 0.
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
- Write: the register updates on the HCLK edge ending the data phase. The new value is visible on outputs and HRDATA from the next cycle, so a back-to-back read returns the new value.
- Read: HRDATA is valid in the data phase, decoded from the captured address. HRDATA is 0 outside a read data phase and on ERROR.
- start pulse: asserted exactly 1 cycle, in the cycle after the CTRL write data phase. busy reads 1 from that same cycle.
- done: sampled on the HCLK edge. busy=0 and done_sticky=1 are readable the next cycle.
- ERROR sequence:
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - An address phase presented during cycle 1 is not accepted (HREADY low).
- HREADY low stalls the capture; data is held.
- Reset mid-BUSY: the FSM returns to IDLE immediately and no start or done effect remains. A pending ERROR is abandoned with HREADYOUT=1.

## Test plan
- Reset then read all 4 registers of ch0 and ch1 -> all reads return 0 with OKAY; HREADYOUT=1 throughout.
- Write SIZE=0x0040_0030, SRC=0x1000_0000, DST=0x2000_0000 to ch1, then read back -> outputs update one cycle after each data phase: length[ch1]=0x40, width[ch1]=0x30; ch0 outputs unchanged.
- Write CTRL=1 on ch1 -> start[1] high exactly 1 cycle; STAT reads 0x1.
  - Then write SRC during BUSY -> two-cycle ERROR and SRC unchanged.
  - Then drive done[1] -> STAT reads 0x2; writing CTRL=0x2 clears it to 0x0.
- Write CTRL=1 on a channel with width=0 -> no start pulse, OKAY response, STAT reads 0x4.
- Access ch=NUM_CH, then a halfword write -> both give the two-cycle ERROR; HRDATA=0; no register changes.
- Assert HRESETn low while ch0 is BUSY -> FSM returns to IDLE; a later start works normally.
